// File: rtl/des_sbox_engine_if.sv
// -----------------------------------------------------------------------------
// des_sbox_engine_if
// Handshake bundle for the DES substitution stage. It carries the input word
// stream and the result stream.
//
// Signals
//   in_valid   master -> slave  DataIn holds a word to substitute
//   in_ready   slave  -> master engine accepts a word this cycle
//   DataIn     master -> slave  48-bit word, S1 input = [47:42] ... S8 = [5:0]
//   out_valid  slave  -> master DataOut holds a completed result
//   out_ready  master -> slave  consumer takes DataOut this cycle
//   DataOut    slave  -> master 32-bit result, S1 = [31:28] ... S8 = [3:0]
//
// The master modport is the producer/consumer side. The slave modport is the
// engine side.
// -----------------------------------------------------------------------------
interface des_sbox_engine_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] DataIn;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] DataOut;

  modport master (
    output in_valid,
    output DataIn,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  DataOut
  );

  modport slave (
    input  in_valid,
    input  DataIn,
    input  out_ready,
    output in_ready,
    output out_valid,
    output DataOut
  );
endinterface

// File: rtl/des_sbox_engine.sv
// -----------------------------------------------------------------------------
// des_sbox_engine
// DES substitution layer. One 48-bit post-expansion/key-XOR word goes through
// the eight FIPS 46-3 S-boxes and produces a 32-bit word for the P permutation.
// The engine evaluates LANES S-boxes per clock. A word therefore needs
// GROUPS = 8/LANES busy cycles. Both sides use valid/ready handshakes.
//
// Parameters
//   LANES      S-boxes evaluated per cycle. Legal values are 1, 2, 4 and 8.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        des_sbox_engine_if.slave
//              (in_valid/in_ready/DataIn, out_valid/out_ready/DataOut)
//
// in_ready is the only combinational output. All other outputs are registers.
// -----------------------------------------------------------------------------
module des_sbox_engine #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  des_sbox_engine_if.slave   bus
);

  localparam int GROUPS = 8 / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

  // Any lane count that does not divide the eight boxes evenly stops
  // elaboration here, so a bad value is never silently truncated.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gBadLanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  // S-box tables. Each table holds 64 nibbles, one row per line.
  // Entry (row*16 + col) sits at bits [255 - 4*(row*16+col) -: 4].
  localparam logic [255:0] S1_TBL = {
    64'hE4D12FB83A6C5907,
    64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50,
    64'hFC8249175B3EA06D };
  localparam logic [255:0] S2_TBL = {
    64'hF18E6B34972DC05A,
    64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F,
    64'hD8A13F42B67C05E9 };
  localparam logic [255:0] S3_TBL = {
    64'hA09E63F51DC7B428,
    64'hD709346A285ECBF1,
    64'hD6498F30B12C5AE7,
    64'h1AD069874FE3B52C };
  localparam logic [255:0] S4_TBL = {
    64'h7DE3069A1285BC4F,
    64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284,
    64'h3F06A1D8945BC72E };
  localparam logic [255:0] S5_TBL = {
    64'h2C417AB6853FD0E9,
    64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E,
    64'hB8C71E2D6F09A453 };
  localparam logic [255:0] S6_TBL = {
    64'hC1AF92680D34E75B,
    64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6,
    64'h432C95FABE17608D };
  localparam logic [255:0] S7_TBL = {
    64'h4B2EF08D3C975A61,
    64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592,
    64'h6BD814A7950FE23C };
  localparam logic [255:0] S8_TBL = {
    64'hD2846FB1A93E50C7,
    64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358,
    64'h21E74A8DFC90356B };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         stateQ;
  logic [GW-1:0]  grpQ;
  logic [47:0]    inRegQ;
  logic [31:0]    resRegQ;
  logic [31:0]    resRegD;
  logic           outValidQ;
  int             grpBase;

  // Looks up one S-box. The outer input bits select the row and the inner
  // four bits select the column.
  function automatic logic [3:0] sboxLookup(input int box, input logic [5:0] b);
    logic [255:0] tbl;
    int           idx;
    idx = 16 * int'({b[5], b[0]}) + int'(b[4:1]);
    case (box)
      0:       tbl = S1_TBL;
      1:       tbl = S2_TBL;
      2:       tbl = S3_TBL;
      3:       tbl = S4_TBL;
      4:       tbl = S5_TBL;
      5:       tbl = S6_TBL;
      6:       tbl = S7_TBL;
      default: tbl = S8_TBL;
    endcase
    return tbl[255 - 4*idx -: 4];
  endfunction

  // Evaluates the current group's boxes. This group is boxes
  // grpQ*LANES .. grpQ*LANES+LANES-1, counted from S1 = 0. Their nibbles are
  // merged into the result register image. Nibbles of the other groups keep
  // their value. Every group runs once per word, so the whole result is
  // rewritten before DONE.
  always_comb begin
    grpBase = int'(grpQ) * LANES;
    resRegD = resRegQ;
    for (int l = 0; l < LANES; l++) begin
      resRegD[31 - 4*(grpBase + l) -: 4] =
        sboxLookup(grpBase + l, inRegQ[47 - 6*(grpBase + l) -: 6]);
    end
  end

  // Control FSM with registered out_valid.
  // DONE holds the result until it is taken. If a new word is offered on that
  // same edge, it goes straight into BUSY without passing through IDLE.
  // Reset drops any partly processed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      grpQ      <= '0;
      inRegQ    <= '0;
      resRegQ   <= '0;
      outValidQ <= 1'b0;
    end else begin
      unique case (stateQ)
        IDLE: begin
          if (bus.in_valid) begin
            inRegQ <= bus.DataIn;
            grpQ   <= '0;
            stateQ <= BUSY;
          end
        end
        BUSY: begin
          resRegQ <= resRegD;
          if (grpQ == LAST_GRP) begin
            grpQ      <= '0;
            outValidQ <= 1'b1;
            stateQ    <= DONE;
          end else begin
            grpQ <= grpQ + GW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValidQ <= 1'b0;
            if (bus.in_valid) begin
              inRegQ <= bus.DataIn;
              grpQ   <= '0;
              stateQ <= BUSY;
            end else begin
              stateQ <= IDLE;
            end
          end
        end
        default: begin
          stateQ    <= IDLE;
          grpQ      <= '0;
          outValidQ <= 1'b0;
        end
      endcase
    end
  end

  // in_ready may look at out_ready in the same cycle. This lets a held
  // result and a new word swap on one edge.
  assign bus.in_ready  = (stateQ == IDLE) || ((stateQ == DONE) && bus.out_ready);
  assign bus.out_valid = outValidQ;
  assign bus.DataOut   = resRegQ;

endmodule

// File: tb/tb_des_sbox_engine.sv
// -----------------------------------------------------------------------------
// tb_des_sbox_engine
// Self-checking bench for des_sbox_engine. It builds three engines
// (LANES = 1, 4, 8) on one clock and reset. It checks them against a
// table-driven model of the DES S-layer.
// -----------------------------------------------------------------------------
module tb_des_sbox_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  des_sbox_engine_if bus1 ();
  des_sbox_engine_if bus4 ();
  des_sbox_engine_if bus8 ();

  des_sbox_engine #(.LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  des_sbox_engine #(.LANES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  des_sbox_engine #(.LANES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // FIPS 46-3 S-boxes as printed in the standard: [box][row][column].
  int SBOX [8][4][16] = '{
    '{ '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},  '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
       '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},  '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13} },
    '{ '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},  '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
       '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},  '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9} },
    '{ '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},  '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
       '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},  '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12} },
    '{ '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},  '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
       '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},  '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14} },
    '{ '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},  '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
       '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},  '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3} },
    '{ '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},  '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
       '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},  '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13} },
    '{ '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},  '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
       '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},  '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12} },
    '{ '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},  '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
       '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},  '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11} }
  };

  // Reference S-layer. It slices six bits per box with shifts and masks.
  // Row = outer bits, column = inner bits.
  function automatic logic [31:0] refModel(input logic [47:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int b, row, col;
      b   = int'((w >> (42 - 6*i)) & 48'h3F);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      r   = (r << 4) | 32'(SBOX[i][row][col]);
    end
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  function automatic int groupsOf(input int which);
    return 8 / which;
  endfunction

  function automatic logic [31:0] dataOf(input int which);
    case (which)
      1:       return bus1.DataOut;
      8:       return bus8.DataOut;
      default: return bus4.DataOut;
    endcase
  endfunction

  function automatic logic validOf(input int which);
    case (which)
      1:       return bus1.out_valid;
      8:       return bus8.out_valid;
      default: return bus4.out_valid;
    endcase
  endfunction

  function automatic logic readyOf(input int which);
    case (which)
      1:       return bus1.in_ready;
      8:       return bus8.in_ready;
      default: return bus4.in_ready;
    endcase
  endfunction

  // Drives one engine's inputs, then waits so in_ready can settle.
  task automatic applyStimulus(input int which, input logic valid,
                               input logic [47:0] data, input logic outReady);
    case (which)
      1: begin bus1.in_valid = valid; bus1.DataIn = data; bus1.out_ready = outReady; end
      8: begin bus8.in_valid = valid; bus8.DataIn = data; bus8.out_ready = outReady; end
      default: begin bus4.in_valid = valid; bus4.DataIn = data; bus4.out_ready = outReady; end
    endcase
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Moves to 2 time units after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // Sends one word to an idle engine and waits for its result.
  // Checks that the word is accepted, that the latency is GROUPS cycles,
  // and that out_valid drops after the result is taken.
  task automatic sendWord(input int which, input logic [47:0] w,
                          output logic [31:0] res);
    int lat;
    applyStimulus(which, 1'b1, w, 1'b0);
    checkOutput("accept_ready", 48'(readyOf(which)), 48'd1);
    cycle();
    applyStimulus(which, 1'b0, 48'h0, 1'b0);
    lat = 0;
    while (!validOf(which) && lat < 20) begin
      cycle();
      lat++;
    end
    checkOutput($sformatf("latency_L%0d", which), 48'(lat), 48'(groupsOf(which)));
    res = dataOf(which);
    applyStimulus(which, 1'b0, 48'h0, 1'b1);
    cycle();
    applyStimulus(which, 1'b0, 48'h0, 1'b0);
    checkOutput("valid_drop", 48'(validOf(which)), 48'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic [47:0] w, wa, wb;
    logic [47:0] words [16];
    logic [31:0] expQ [$];
    int          accQ [$];
    int          lanes [3];
    int          wIdx, nOut, c, cnt, s4Exp;
    logic        fireIn, fireOut;

    lanes = '{1, 4, 8};
    rst_n = 1'b0;
    applyStimulus(1, 1'b0, 48'h0, 1'b0);
    applyStimulus(4, 1'b0, 48'h0, 1'b0);
    applyStimulus(8, 1'b0, 48'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // Reset state of all three engines.
    foreach (lanes[i]) begin
      checkOutput("reset_valid", 48'(validOf(lanes[i])), 48'd0);
      checkOutput("reset_data",  48'(dataOf(lanes[i])),  48'd0);
      checkOutput("reset_ready", 48'(readyOf(lanes[i])), 48'd1);
    end

    // All-zero word with 4 lanes, and all-ones word with 1 and 8 lanes.
    sendWord(4, 48'h0, res);
    checkOutput("zero_L4", 48'(res), 48'hEFA72C4D);
    sendWord(1, 48'hFFFF_FFFF_FFFF, res);
    checkOutput("ones_L1", 48'(res), 48'hD9CE3DCB);
    sendWord(8, 48'hFFFF_FFFF_FFFF, res);
    checkOutput("ones_L8", 48'(res), 48'hD9CE3DCB);

    // Random words through each lane configuration.
    foreach (lanes[i]) begin
      for (int k = 0; k < 4; k++) begin
        w = rand48();
        sendWord(lanes[i], w, res);
        checkOutput($sformatf("rand_L%0d", lanes[i]), 48'(res), 48'(refModel(w)));
      end
    end

    // S4 sweep. The other boxes see 0, so their nibbles stay fixed.
    for (int idx = 0; idx < 64; idx++) begin
      w = 48'(idx) << 24;
      sendWord(4, w, res);
      checkOutput("s4_model", 48'(res), 48'(refModel(w)));
      checkOutput("s4_others", 48'(res & 32'hFFF0FFFF), 48'hEFA02C4D);
      s4Exp = -1;
      case (idx)
        0:  s4Exp = 7;
        1:  s4Exp = 13;
        2:  s4Exp = 13;
        3:  s4Exp = 8;
        63: s4Exp = 14;
        default: s4Exp = -1;
      endcase
      if (s4Exp >= 0) checkOutput($sformatf("s4_idx%0d", idx), 48'(res[19:16]), 48'(s4Exp));
    end

    // Backpressure. The next word is offered the whole time and must not
    // disturb the busy word or the held result.
    wa = rand48();
    wb = rand48();
    applyStimulus(4, 1'b1, wa, 1'b0);
    checkOutput("bp_accept", 48'(readyOf(4)), 48'd1);
    cycle();
    applyStimulus(4, 1'b1, wb, 1'b0);
    cnt = 0;
    while (!validOf(4) && cnt < 20) begin cycle(); cnt++; end
    checkOutput("bp_latency", 48'(cnt), 48'd2);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_ready_low", 48'(readyOf(4)), 48'd0);
      checkOutput("bp_valid_hold", 48'(validOf(4)), 48'd1);
      checkOutput("bp_data_hold", 48'(dataOf(4)), 48'(refModel(wa)));
      cycle();
    end
    applyStimulus(4, 1'b1, wb, 1'b1);
    checkOutput("bp_swap_ready", 48'(readyOf(4)), 48'd1);
    cycle();
    applyStimulus(4, 1'b0, 48'h0, 1'b0);
    checkOutput("bp_swap_valid", 48'(validOf(4)), 48'd0);
    cnt = 0;
    while (!validOf(4) && cnt < 20) begin cycle(); cnt++; end
    checkOutput("bp_new_latency", 48'(cnt), 48'd2);
    checkOutput("bp_new_data", 48'(dataOf(4)), 48'(refModel(wb)));
    applyStimulus(4, 1'b0, 48'h0, 1'b1);
    cycle();
    applyStimulus(4, 1'b0, 48'h0, 1'b0);

    // Back-to-back stream with in_valid and out_ready held high.
    // A word accepted at edge a shows its result after edge a+GROUPS. That
    // is loop iteration a+GROUPS+1. Each result hand-off is also an accept.
    for (int k = 0; k < 16; k++) words[k] = rand48();
    wIdx = 0;
    nOut = 0;
    c    = 0;
    applyStimulus(4, 1'b1, words[0], 1'b1);
    while (nOut < 16 && c < 200) begin
      fireIn  = bus4.in_valid && bus4.in_ready;
      fireOut = bus4.out_valid && bus4.out_ready;
      if (fireOut) begin
        checkOutput("stream_pending", 48'(expQ.size() > 0), 48'd1);
        if (expQ.size() > 0) begin
          checkOutput("stream_data", 48'(bus4.DataOut), 48'(expQ.pop_front()));
          checkOutput("stream_latency", 48'(c - accQ.pop_front()), 48'(groupsOf(4) + 1));
        end
        if (wIdx < 16) checkOutput("stream_nobubble", 48'(fireIn), 48'd1);
        nOut++;
      end
      if (fireIn) begin
        expQ.push_back(refModel(words[wIdx]));
        accQ.push_back(c);
        wIdx++;
      end
      cycle();
      c++;
      if (fireIn) applyStimulus(4, wIdx < 16, (wIdx < 16) ? words[wIdx] : 48'h0, 1'b1);
    end
    checkOutput("stream_count", 48'(nOut), 48'd16);
    applyStimulus(4, 1'b0, 48'h0, 1'b0);
    cycle();

    // Reset in the middle of an 8-cycle busy phase.
    w = rand48();
    applyStimulus(1, 1'b1, w, 1'b0);
    cycle();
    applyStimulus(1, 1'b0, 48'h0, 1'b0);
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 48'(validOf(1)), 48'd0);
    checkOutput("midrst_data", 48'(dataOf(1)), 48'd0);
    cycle();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_ready", 48'(readyOf(1)), 48'd1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (validOf(1)) cnt++;
      cycle();
    end
    checkOutput("midrst_no_stale", 48'(cnt), 48'd0);
    w = rand48();
    sendWord(1, w, res);
    checkOutput("midrst_next", 48'(res), 48'(refModel(w)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
